// File: rtl/led_fader.sv
`timescale 1ns/1ps
// led_fader: per-channel LED brightness fader with PWM output.
// Each LED bit ramps its 8-bit brightness toward full-on or full-off at
// STEP counts per fade tick, and the brightness is rendered as PWM.
// Fade ticks come from a prescaler that runs only while enabled.
module led_fader #(
  parameter int PRESCALE = 1024,
  parameter int STEP     = 8,
  parameter int NCH      = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           enable,
  input  logic [NCH-1:0] led_in,
  input  logic [2:0]     level_sel,
  output logic [NCH-1:0] led_out,
  output logic [7:0]     level,
  output logic           fading
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [8:0]     STEP9    = 9'(STEP);

  logic [NCH-1:0] r_led_q;
  logic [PW-1:0]  r_pre_cnt;
  logic [7:0]     r_pwm_cnt;
  logic [7:0]     r_bright [NCH];
  logic [NCH-1:0] r_led_out;

  logic           w_tick;
  logic [7:0]     w_tgt        [NCH];
  logic [8:0]     w_up         [NCH];
  logic [8:0]     w_dn         [NCH];
  logic [7:0]     w_bright_nxt [NCH];
  logic [NCH-1:0] w_diff;

  assign w_tick = enable && (r_pre_cnt == PRE_LAST);

  // Per-channel target and saturating next brightness for the coming tick.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every output gets a default before the if chain so no latch is inferred.
      w_tgt[i]        = r_led_q[i] ? 8'hFF : 8'h00;
      w_up[i]         = {1'b0, r_bright[i]} + STEP9;
      w_dn[i]         = {1'b0, r_bright[i]} - STEP9;
      w_bright_nxt[i] = r_bright[i];
      if (r_bright[i] < w_tgt[i]) begin
        // Bit 8 set means the sum passed 255: clip to full-on.
        w_bright_nxt[i] = w_up[i][8] ? 8'hFF : w_up[i][7:0];
      end else if (r_bright[i] > w_tgt[i]) begin
        // Bit 8 set means the difference went negative: clip to off.
        w_bright_nxt[i] = w_dn[i][8] ? 8'h00 : w_dn[i][7:0];
      end
      w_diff[i] = (r_bright[i] != w_tgt[i]);
    end
  end

  // Input register, prescaler and PWM counter.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      r_led_q   <= '0;
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_led_q <= led_in;
      if (enable) begin
        r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PW'(1);
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
    end
  end

  // Brightness registers step once per fade tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: this small register array is reset on purpose; a fade must restart from dark.
      for (int i = 0; i < NCH; i++) r_bright[i] <= 8'h00;
    end else if (w_tick) begin
      for (int i = 0; i < NCH; i++) r_bright[i] <= w_bright_nxt[i];
    end
  end

  // Registered PWM compare; 255 is forced fully on, disabled forces all off.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_led_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_led_out[i] <= enable && ((r_bright[i] == 8'hFF) || (r_pwm_cnt < r_bright[i]));
      end
    end
  end

  assign led_out = r_led_out;
  assign level   = r_bright[level_sel];
  assign fading  = |w_diff;

endmodule

// File: tb/tb_led_fader.sv
`timescale 1ns/1ps
// tb_led_fader: directed tests for led_fader.
// Instance A uses PRESCALE=4, STEP=64; instance B uses PRESCALE=4096, STEP=64
// for the duty-cycle measurement.
module tb_led_fader;

  logic       clk = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic       rst_a = 1'b1, en_a = 1'b1;
  logic [7:0] led_in_a = 8'hFF;
  logic [2:0] sel_a = 3'd0;
  logic [7:0] led_out_a, level_a;
  logic       fading_a;

  logic       rst_b = 1'b1, en_b = 1'b0;
  logic [7:0] led_in_b = 8'h00;
  logic [2:0] sel_b = 3'd7;
  logic [7:0] led_out_b, level_b;
  logic       fading_b;

  led_fader #(.PRESCALE(4), .STEP(64), .NCH(8)) u_dut_a (
    .CLK(clk), .RST(rst_a), .enable(en_a), .led_in(led_in_a), .level_sel(sel_a),
    .led_out(led_out_a), .level(level_a), .fading(fading_a)
  );

  led_fader #(.PRESCALE(4096), .STEP(64), .NCH(8)) u_dut_b (
    .CLK(clk), .RST(rst_b), .enable(en_b), .led_in(led_in_b), .level_sel(sel_b),
    .led_out(led_out_b), .level(level_b), .fading(fading_b)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; outputs are then sampled 1ns after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply a one-cycle reset to instance A with the given pattern already on led_in.
  task automatic reset_a(input logic [7:0] pat);
    led_in_a = pat;
    en_a     = 1'b1;
    sel_a    = 3'd0;
    rst_a    = 1'b1;
    cyc(1);
    rst_a    = 1'b0;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; en_a = 1'b1; led_in_a = 8'hFF; sel_a = 3'd0;
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      checks++; if (led_out_a !== 8'h00) begin errors++; $display("FAIL reset_led_out[%0d]: got %02h expected 00", k, led_out_a); end
      checks++; if (level_a !== 8'h00) begin errors++; $display("FAIL reset_level[%0d]: got %0d expected 0", k, level_a); end
      checks++; if (fading_a !== 1'b0) begin errors++; $display("FAIL reset_fading[%0d]: got %b expected 0", k, fading_a); end
    end
    rst_a = 1'b0;
    #1;
    checks++; if (fading_a !== 1'b0) begin errors++; $display("FAIL reset_fading_after: got %b expected 0", fading_a); end
    cyc(1);
    checks++; if (led_out_a !== 8'h00) begin errors++; $display("FAIL reset_first_led_out: got %02h expected 00", led_out_a); end
    checks++; if (level_a !== 8'h00) begin errors++; $display("FAIL reset_first_level: got %0d expected 0", level_a); end
    checks++; if (fading_a !== 1'b1) begin errors++; $display("FAIL reset_first_fading: got %b expected 1", fading_a); end
  endtask

  task automatic test_ramp_up;
    logic [7:0] exp_lvl [4];
    exp_lvl = '{8'd64, 8'd128, 8'd192, 8'd255};
    reset_a(8'h01);
    checks++; if (fading_a !== 1'b0) begin errors++; $display("FAIL up_fading_pre: got %b expected 0", fading_a); end
    cyc(1);
    checks++; if (fading_a !== 1'b1) begin errors++; $display("FAIL up_fading_start: got %b expected 1", fading_a); end
    cyc(2);
    checks++; if (level_a !== 8'd0) begin errors++; $display("FAIL up_level_pre_tick: got %0d expected 0", level_a); end
    cyc(1);
    checks++; if (level_a !== exp_lvl[0]) begin errors++; $display("FAIL up_level_tick1: got %0d expected %0d", level_a, exp_lvl[0]); end
    for (int t = 1; t < 4; t++) begin
      cyc(4);
      checks++; if (level_a !== exp_lvl[t]) begin errors++; $display("FAIL up_level_tick%0d: got %0d expected %0d", t + 1, level_a, exp_lvl[t]); end
    end
    checks++; if (fading_a !== 1'b0) begin errors++; $display("FAIL up_fading_done: got %b expected 0", fading_a); end
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      checks++; if (led_out_a !== 8'h01) begin errors++; $display("FAIL up_led_full[%0d]: got %02h expected 01", k, led_out_a); end
    end
  endtask

  // Continues from the end of test_ramp_up: bright[0]=255, prescaler at 0.
  task automatic test_ramp_down;
    logic [7:0] exp_lvl [4];
    exp_lvl = '{8'd191, 8'd127, 8'd63, 8'd0};
    led_in_a = 8'h00;
    cyc(1);
    checks++; if (fading_a !== 1'b1) begin errors++; $display("FAIL down_fading_start: got %b expected 1", fading_a); end
    checks++; if (level_a !== 8'd255) begin errors++; $display("FAIL down_level_hold: got %0d expected 255", level_a); end
    cyc(3);
    checks++; if (level_a !== exp_lvl[0]) begin errors++; $display("FAIL down_level_tick1: got %0d expected %0d", level_a, exp_lvl[0]); end
    for (int t = 1; t < 4; t++) begin
      cyc(4);
      checks++; if (level_a !== exp_lvl[t]) begin errors++; $display("FAIL down_level_tick%0d: got %0d expected %0d", t + 1, level_a, exp_lvl[t]); end
    end
    checks++; if (fading_a !== 1'b0) begin errors++; $display("FAIL down_fading_done: got %b expected 0", fading_a); end
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      checks++; if (led_out_a !== 8'h00) begin errors++; $display("FAIL down_led_off[%0d]: got %02h expected 00", k, led_out_a); end
    end
  endtask

  task automatic test_enable_freeze;
    reset_a(8'h01);
    cyc(8);
    checks++; if (level_a !== 8'd128) begin errors++; $display("FAIL freeze_level_start: got %0d expected 128", level_a); end
    cyc(1);
    en_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      checks++; if (led_out_a !== 8'h00) begin errors++; $display("FAIL freeze_led_out[%0d]: got %02h expected 00", k, led_out_a); end
      checks++; if (level_a !== 8'd128) begin errors++; $display("FAIL freeze_level[%0d]: got %0d expected 128", k, level_a); end
    end
    en_a = 1'b1;
    cyc(1);
    // Held pwm_cnt is 9, below 128, so channel 0 lights on the first enabled edge.
    checks++; if (led_out_a !== 8'h01) begin errors++; $display("FAIL freeze_led_resume: got %02h expected 01", led_out_a); end
    cyc(1);
    checks++; if (level_a !== 8'd128) begin errors++; $display("FAIL freeze_level_pre_tick: got %0d expected 128", level_a); end
    cyc(1);
    checks++; if (level_a !== 8'd192) begin errors++; $display("FAIL freeze_level_tick: got %0d expected 192", level_a); end
  endtask

  task automatic test_tick_collision;
    reset_a(8'h01);
    cyc(7);
    checks++; if (level_a !== 8'd64) begin errors++; $display("FAIL coll_level_pre: got %0d expected 64", level_a); end
    led_in_a = 8'h00;
    cyc(1);
    checks++; if (level_a !== 8'd128) begin errors++; $display("FAIL coll_level_old_target: got %0d expected 128", level_a); end
    checks++; if (fading_a !== 1'b1) begin errors++; $display("FAIL coll_fading: got %b expected 1", fading_a); end
    cyc(4);
    checks++; if (level_a !== 8'd64) begin errors++; $display("FAIL coll_level_new_target: got %0d expected 64", level_a); end
  endtask

  task automatic test_reversal_reset;
    reset_a(8'h01);
    cyc(8);
    checks++; if (level_a !== 8'd128) begin errors++; $display("FAIL rev_level_start: got %0d expected 128", level_a); end
    led_in_a = 8'h00;
    cyc(3);
    checks++; if (level_a !== 8'd128) begin errors++; $display("FAIL rev_level_pre_tick: got %0d expected 128", level_a); end
    cyc(1);
    checks++; if (level_a !== 8'd64) begin errors++; $display("FAIL rev_level_tick: got %0d expected 64", level_a); end
    led_in_a = 8'h01;
    rst_a    = 1'b1;
    cyc(1);
    rst_a    = 1'b0;
    checks++; if (level_a !== 8'd0) begin errors++; $display("FAIL rev_reset_level: got %0d expected 0", level_a); end
    checks++; if (fading_a !== 1'b0) begin errors++; $display("FAIL rev_reset_fading: got %b expected 0", fading_a); end
    checks++; if (led_out_a !== 8'h00) begin errors++; $display("FAIL rev_reset_led_out: got %02h expected 00", led_out_a); end
    cyc(3);
    checks++; if (level_a !== 8'd0) begin errors++; $display("FAIL rev_restart_pre_tick: got %0d expected 0", level_a); end
    cyc(1);
    checks++; if (level_a !== 8'd64) begin errors++; $display("FAIL rev_restart_tick: got %0d expected 64", level_a); end
  endtask

  task automatic test_multi_channel;
    reset_a(8'h05);
    cyc(4);
    sel_a = 3'd0; #1;
    checks++; if (level_a !== 8'd64) begin errors++; $display("FAIL multi_level_ch0: got %0d expected 64", level_a); end
    sel_a = 3'd1; #1;
    checks++; if (level_a !== 8'd0) begin errors++; $display("FAIL multi_level_ch1: got %0d expected 0", level_a); end
    sel_a = 3'd2; #1;
    checks++; if (level_a !== 8'd64) begin errors++; $display("FAIL multi_level_ch2: got %0d expected 64", level_a); end
    checks++; if (fading_a !== 1'b1) begin errors++; $display("FAIL multi_fading: got %b expected 1", fading_a); end
    sel_a = 3'd0;
  endtask

  task automatic test_duty_cycle;
    int high_cnt;
    int low_bad;
    high_cnt = 0;
    low_bad  = 0;
    led_in_b = 8'h80; en_b = 1'b1; sel_b = 3'd7; rst_b = 1'b1;
    cyc(1);
    rst_b = 1'b0;
    cyc(4095);
    checks++; if (level_b !== 8'd0) begin errors++; $display("FAIL duty_level_pre_tick: got %0d expected 0", level_b); end
    cyc(1);
    checks++; if (level_b !== 8'd64) begin errors++; $display("FAIL duty_level_tick: got %0d expected 64", level_b); end
    for (int k = 0; k < 256; k++) begin
      cyc(1);
      if (led_out_b[7] === 1'b1) high_cnt++;
      if (led_out_b[6:0] !== 7'h00) low_bad++;
    end
    checks++; if (high_cnt !== 64) begin errors++; $display("FAIL duty_high_count: got %0d expected 64", high_cnt); end
    checks++; if (low_bad !== 0) begin errors++; $display("FAIL duty_other_channels: got %0d lit cycles expected 0", low_bad); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_enable_freeze();
    test_tick_collision();
    test_reversal_reset();
    test_multi_channel();
    test_duty_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the whole run in case something stalls.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Output stage directly downstream of the counter/accumulator block; consumes its 8-bit `led` pattern word and drives the physical LEDs.
- Each LED bit gets its own 8-bit brightness register. Brightness ramps toward full-on or full-off at a fixed rate, giving smooth fades instead of hard toggles.
- Brightness is rendered as a per-channel PWM waveform. A readback port and a busy flag are provided for debug.

Parameters:
- PRESCALE, 1024: enabled clock cycles per fade tick; must be >= 1.
- STEP, 8: brightness change applied per fade tick; range 1..255.
- NCH, 8: number of LED channels; fixed to 8 in this revision.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- enable  input  1  run enable; when low, all counters and brightness registers hold.
- led_in  input  8  target pattern from the upstream counter stage; bit i = 1 means channel i targets full-on.
- level_sel  input  3  channel index for the `level` readback.
- led_out  output  8  PWM-driven LED outputs, registered.
- level  output  8  brightness of channel `level_sel`, combinational from registers.
- fading  output  1  high while any channel's brightness differs from its target.

Behaviour:
- Reset (RST=1 at a clock edge) clears the following to 0 on that edge:
  - led_q, pre_cnt, pwm_cnt, bright[0..7], led_out.
  - Consequently level=0 and fading=0 after reset.
  - Reset overrides enable and all other inputs.
- Input register: led_q <= led_in every non-reset cycle, independent of enable. This is one cycle of input latency.
- Prescaler `pre_cnt`:
  - Width is ceil(log2(PRESCALE)), minimum 1.
  - While enable=1, it counts 0..PRESCALE-1 and wraps to 0.
  - tick = enable && (pre_cnt == PRESCALE-1). With PRESCALE=1, tick is high on every enabled cycle.
  - The first tick occurs on the PRESCALE-th enabled cycle after reset.
- PWM counter `pwm_cnt`: 8 bits, increments on each enabled cycle, wraps 255 -> 0. Independent of the prescaler.
- Fade update, on each tick, per channel i:
  - Target is tgt[i] = led_q[i] ? 255 : 0.
  - If bright < tgt: bright <= min(bright + STEP, 255).
  - If bright > tgt: bright <= max(bright - STEP, 0).
  - If bright == tgt: no change.
  - Arithmetic is done at 9 bits, then saturated; bright never wraps.
- Simultaneous tick and led_in change: the tick uses the previously registered led_q, so the new target takes effect from the next tick.
- Target reversal mid-ramp: takes effect at the next tick from the current brightness; there is no restart from the endpoints.
- PWM output (registered), per channel:
  - led_out[i] <= enable && (bright[i] == 255 || pwm_cnt < bright[i]).
  - bright=0 gives constantly off; bright=255 gives constantly on.
  - For 0 < b < 255, the LED is high for exactly b cycles of every 256 enabled cycles.
  - led_out reflects bright and pwm_cnt with one cycle of latency.
- enable=0:
  - pre_cnt, pwm_cnt and bright hold their values.
  - led_out goes to 0 on the next edge.
  - led_q continues sampling.
  - When enable returns to 1, counting resumes from the held values.
- level = bright[level_sel].
- fading = OR over i of (bright[i] != tgt[i]), combinational.
- Reset mid-fade: all brightness is lost; the next fade starts from 0 once the reset cycle is over.

Test Plan (PRESCALE=4, STEP=64 unless noted):
- Reset check: RST=1 for 2 cycles with led_in=0xFF, enable=1 -> led_out=0x00, level=0, fading=0 throughout the reset cycles and the first cycle after.
- Ramp-up with saturation: led_in=0x01, enable=1, level_sel=0 -> fading=1 from the cycle after led_q updates. level steps 64, 128, 192, 255 on ticks 1..4 (192+64 clips to 255). fading=0 after the 4th tick; led_out[0] is then constantly 1.
- Ramp-down with saturation: from bright[0]=255, set led_in=0x00 -> level steps 191, 127, 63, 0 on the next 4 ticks. After that, led_out[0] is constantly 0 and fading=0.
- Duty cycle (PRESCALE=4096, STEP=64): led_in=0x80; after the first tick bright[7]=64. Over the following 256 consecutive enabled cycles, led_out[7] is high for exactly 64 cycles. led_out[6:0] stay 0.
- Enable freeze: during the ramp-up at level=128, drop enable for 20 cycles -> led_out=0x00 from the next edge, level stays at 128, no ticks occur. After re-enable, the next tick arrives after the remaining prescaler count and level goes to 192.
- Mid-fade reset and reversal:
  - At level=128 with led_in=0x01, toggle led_in to 0x00 -> the next tick gives level=64.
  - Then assert RST for 1 cycle with led_in=0x01 -> level=0.
  - The ramp restarts, giving 64 on the first tick after PRESCALE enabled cycles.
